// File: rtl/config_responder.sv
// Register-bank responder for the 4-bit address / 4-bit data config handshake.
// Commits one write per valid pulse, acks after ACK_DELAY cycles, rejects RO writes.
module config_responder #(
  parameter int unsigned ACK_DELAY   = 1,
  parameter logic [15:0] RO_MASK     = 16'h0001,
  parameter logic [3:0]  ID_VALUE    = 4'hA,
  parameter logic [3:0]  RESET_VALUE = 4'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid,
  input  logic [3:0]  address,
  input  logic [3:0]  data,
  input  logic        hold,
  output logic        ack,
  output logic        rejected,
  input  logic [3:0]  rd_addr,
  output logic [3:0]  rd_data,
  output logic [63:0] regs_flat,
  output logic [7:0]  wr_count
);

  typedef enum logic [1:0] {
    IDLE,
    DELAY,
    ACK,
    REARM
  } state_e;

  // Counter starts one below the delay: the commit edge itself is the last cycle.
  localparam logic [2:0] CNT_INIT = 3'(ACK_DELAY - 1);

  state_e      state_q, state_d;
  logic [3:0]  addr_q, addr_d;
  logic [3:0]  data_q, data_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        ack_q, ack_d;
  logic        rej_q, rej_d;
  logic [7:0]  wcnt_q, wcnt_d;
  logic        we;
  logic [3:0]  regs_q [16];

  // Next-state, latch and commit decisions for the handshake.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    wcnt_d  = wcnt_q;
    ack_d   = 1'b0;
    rej_d   = 1'b0;
    we      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (valid && !hold) begin
          if (RO_MASK[address]) begin
            rej_d   = 1'b1;
            state_d = REARM;
          end else begin
            addr_d  = address;
            data_d  = data;
            cnt_d   = CNT_INIT;
            state_d = DELAY;
          end
        end
      end
      DELAY: begin
        if (!hold) begin
          if (cnt_q == 3'd0) begin
            we      = 1'b1;
            ack_d   = 1'b1;
            state_d = ACK;
            if (wcnt_q != 8'hFF) begin
              wcnt_d = wcnt_q + 8'd1;
            end
          end else begin
            cnt_d = cnt_q - 3'd1;
          end
        end
      end
      ACK: begin
        state_d = REARM;
      end
      REARM: begin
        if (!valid) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Control state; reset aborts any transaction in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= 4'h0;
      data_q  <= 4'h0;
      cnt_q   <= 3'd0;
      ack_q   <= 1'b0;
      rej_q   <= 1'b0;
      wcnt_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
      rej_q   <= rej_d;
      wcnt_q  <= wcnt_d;
    end
  end

  // Register file; only writable addresses are ever latched, so RO entries stay fixed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) begin
        regs_q[i] <= RO_MASK[i] ? ID_VALUE : RESET_VALUE;
      end
    end else if (we) begin
      regs_q[addr_q] <= data_q;
    end
  end

  for (genvar g = 0; g < 16; g++) begin : g_flat
    assign regs_flat[4*g +: 4] = regs_q[g];
  end

  assign rd_data  = regs_q[rd_addr];
  assign ack      = ack_q;
  assign rejected = rej_q;
  assign wr_count = wcnt_q;

endmodule

// File: doc/config_responder.md
Name: config_responder

Overview:
- Register-bank end of the 4-bit address / 4-bit data configuration handshake.
- Accepts one write per assertion of the initiator's valid, commits it to a 16 x 4-bit register file and answers with a one-cycle ack.
- Rejects writes to read-only addresses by withholding ack, so the initiator times out and raises its fault.
- Exposes the register contents to downstream logic through a flat bus and a combinational read port.

Parameters:
- ACK_DELAY, 1: cycles between accepting a write and asserting ack. Legal range 1..5, which keeps ack inside the initiator's 8-cycle timeout window.
- RO_MASK, 16'h0001: bit i = 1 makes address i read-only. Address 0 is the ID register.
- ID_VALUE, 4'hA: reset value of every read-only register.
- RESET_VALUE, 4'h0: reset value of every writable register.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- valid  input  1  initiator write request, held until ack is seen
- address  input  4  target register index
- data  input  4  write data
- hold  input  1  stall: blocks acceptance and freezes the delay counter
- ack  output  1  registered, one-cycle write acknowledge
- rejected  output  1  registered, one-cycle pulse on a read-only write attempt
- rd_addr  input  4  read port address
- rd_data  output  4  combinational read: regs[rd_addr]
- regs_flat  output  64  regs[i] on bits [4i+3:4i]
- wr_count  output  8  committed writes, saturates at 8'hFF

Behaviour:
- Reset (asynchronous, active-high):
  - state = IDLE; ack = 0; rejected = 0; wr_count = 0; delay counter = 0.
  - Read-only registers = ID_VALUE; all other registers = RESET_VALUE.
  - Reset asserted mid-transaction aborts it: no ack, no register write.
- All outputs except rd_data are registered. Transitions below take effect on the rising edge.
- State machine:
  - IDLE:
    - valid=1 and hold=0, writable address: latch address and data, load counter = ACK_DELAY-1, go to DELAY.
    - valid=1 and hold=0, read-only address: rejected <= 1 for one cycle, go to REARM. No write, no ack.
    - valid=1 and hold=1: stay in IDLE, nothing latched.
  - DELAY:
    - hold=1: counter frozen.
    - Otherwise, when counter==0: write latched data to regs[latched address], ack <= 1, increment wr_count (saturating), go to ACK.
    - Otherwise: decrement counter.
  - ACK: ack <= 0, go to REARM. Ack is high for exactly one cycle.
  - REARM: wait for valid==0, then go to IDLE. Valid stays high for at least one cycle after ack, so this state guarantees exactly one write per valid pulse.
- Latency: valid sampled at edge k (IDLE, hold low) gives ack high and the register updated after edge k+ACK_DELAY.
- Input sampling:
  - address and data are sampled only at acceptance.
  - Changes to them during DELAY, ACK or REARM are ignored.
- Initiator abandons while in DELAY (valid drops before the counter expires): the write still commits and ack still pulses, then REARM sees valid=0 and returns to IDLE. The initiator ignores the late ack.
- rd_data, read/write collision: a read of the address being written returns the old value in the commit cycle and the new value afterwards.
- Read-only registers can never be changed by the handshake.
- wr_count stays at 8'hFF once saturated.

Test Plan:
- Reset, then valid=1, address=4'h3, data=4'h5, ACK_DELAY=1, held until ack -> ack high exactly one cycle, 1 cycle after acceptance; regs_flat[15:12]=4'h5; wr_count=1; rd_addr=3 gives rd_data=4'h5.
- Valid held high for 4 cycles after ack -> no second write, wr_count stays 1. Drop valid, then write address 4'h3 with data 4'h9 -> second ack; register holds 4'h9; wr_count=2.
- Write address 0, data 4'h7 -> rejected pulses once; ack never asserts; rd_data at address 0 stays 4'hA.
- ACK_DELAY=5 with hold=1 for 3 cycles during DELAY -> ack delayed exactly 3 extra cycles (8 cycles after acceptance); register written once.
- rst asserted during DELAY -> ack stays 0; target register returns to RESET_VALUE; wr_count=0; next write completes normally.
- 260 back-to-back valid write pulses to address 4'hF -> wr_count=8'hFF; regs_flat[63:60] equals the data of the last write.
